lot_sensor_sequencer: RTL

Stimulus generator for the parking-lot sensor pair. It turns one-cycle "car enters" / "car exits" requests into the exact a/b beam-break waveform that a real car produces. Each request becomes a four-phase Gray sequence on `a`/`b`, with each phase held for a programmable number of cycles. The outputs drive GPIO toward the lot counter on the DE1-SoC, or feed the counter directly in simulation. The block keeps its own shadow occupancy so benches and on-board demos can check the counter's display.

---
 rtl/lot_sensor_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lot_sensor_sequencer.sv
// lot_sensor_sequencer
// Turns one-cycle car enter/exit requests into the four-phase Gray a/b
// beam-break waveform a real car produces, with each phase held for
// PHASE_CYCLES cycles, and tracks a shadow occupancy count.
//
// Optional feature macro: LOT_SIM_GUARD_EN
//   defined   - enter at full lot / exit at empty lot is refused (o_rejected)
//   undefined - such requests still run the full waveform; occupancy saturates
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_req_enter   one-cycle car-entry request (sampled only while o_ready)
//   i_req_exit    one-cycle car-exit request  (sampled only while o_ready)
//   o_ready       idle, accepting requests (combinational from state)
//   o_a, o_b      outer / inner beam (1 = blocked), registered
//   o_done        one-cycle pulse when a sequence completes, registered
//   o_rejected    one-cycle pulse when a request is refused, registered
//   o_occupancy   shadow car count 0..CAPACITY, registered
module lot_sensor_sequencer #(
  parameter int PHASE_CYCLES = 4,
  parameter int CAPACITY     = 25
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_enter,
  input  logic       i_req_exit,
  output logic       o_ready,
  output logic       o_a,
  output logic       o_b,
  output logic       o_done,
  output logic       o_rejected,
  output logic [4:0] o_occupancy
);

  typedef enum logic [2:0] {S_IDLE, S_PH1, S_PH2, S_PH3, S_PH4} state_t;

  localparam logic [7:0] RELOAD = 8'(PHASE_CYCLES - 1);
  localparam logic [4:0] CAP    = 5'(CAPACITY);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_dir, w_dir_nxt;          // 0 = enter, 1 = exit
  logic       r_a, r_b, w_a_nxt, w_b_nxt;
  logic       r_done, w_done_nxt;
  logic       r_rej, w_rej_nxt;
  logic [4:0] r_occ, w_occ_nxt;
  logic       w_blocked;

`ifdef LOT_SIM_GUARD_EN
  assign w_blocked = (i_req_enter && (r_occ >= CAP)) || (i_req_exit && (r_occ == 5'd0));
`else
  assign w_blocked = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    w_rej_nxt   = 1'b0;
    w_occ_nxt   = r_occ;
    w_a_nxt     = 1'b0;
    w_b_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req_enter && i_req_exit) begin
          w_rej_nxt = 1'b1;
        end else if (i_req_enter || i_req_exit) begin
          if (w_blocked) begin
            w_rej_nxt = 1'b1;
          end else begin
            w_dir_nxt   = i_req_exit;
            w_cnt_nxt   = RELOAD;
            w_state_nxt = S_PH1;
          end
        end
      end
      default: begin
        if (r_cnt == 8'd0) begin
          w_cnt_nxt = RELOAD;
          case (r_state)
            S_PH1:   w_state_nxt = S_PH2;
            S_PH2:   w_state_nxt = S_PH3;
            S_PH3:   w_state_nxt = S_PH4;
            default: begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              if (!r_dir) begin
                if (r_occ < CAP) w_occ_nxt = r_occ + 5'd1;
              end else begin
                if (r_occ != 5'd0) w_occ_nxt = r_occ - 5'd1;
              end
            end
          endcase
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
    endcase

    // a/b are decoded from the next state so the waveform lines up with the
    // state register: PH1 appears right after the accepting edge.
    if (!w_dir_nxt) begin
      w_a_nxt = (w_state_nxt == S_PH1) || (w_state_nxt == S_PH2);
      w_b_nxt = (w_state_nxt == S_PH2) || (w_state_nxt == S_PH3);
    end else begin
      w_a_nxt = (w_state_nxt == S_PH2) || (w_state_nxt == S_PH3);
      w_b_nxt = (w_state_nxt == S_PH1) || (w_state_nxt == S_PH2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_dir   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_done  <= 1'b0;
      r_rej   <= 1'b0;
      r_occ   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_done  <= w_done_nxt;
      r_rej   <= w_rej_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_done      = r_done;
  assign o_rejected  = r_rej;
  assign o_occupancy = r_occ;

endmodule
